retire_trace_buffer: RTL and testbench

Captures the per-instruction retirement record produced by the single-cycle RV32I core: PC, instruction, register write-back and memory write. Records go into a DEPTH-entry FIFO and are drained as a 6-word valid/ready stream to the trace sink (testbench monitor or debug UART bridge). The block sits directly downstream of the core's retirement ports. It also keeps a running retired-instruction count and a sticky overflow flag.

---
 rtl/retire_trace_buffer_if.sv | 15 +
 rtl/retire_trace_buffer.sv | 101 ++++++++++
 tb/tb_retire_trace_buffer.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/retire_trace_buffer_if.sv
// retire_trace_buffer_if: valid/ready trace word stream between the buffer and the trace sink
// Signals:
//   valid  source -> sink  data holds a valid trace word
//   ready  sink -> source  sink accepts the word this cycle
//   data   source -> sink  current trace word (XLEN bits)
//   last   source -> sink  current word is the final word of its record
// Modports: master = trace source (the buffer), slave = trace sink.
interface retire_trace_buffer_if #(parameter int XLEN = 32);
   logic            valid;
   logic            ready;
   logic [XLEN-1:0] data;
   logic            last;
   modport master (output valid, data, last, input ready);
   modport slave (input valid, data, last, output ready);
endinterface

// File: rtl/retire_trace_buffer.sv
// retire_trace_buffer: FIFO of retirement records serialized as 6-word valid/ready trace stream
// Parameters: XLEN field/word width, DEPTH FIFO depth in records (power of two, >= 2).
// Ports:
//   clk_i, rst_i                 clock and synchronous active-high reset
//   update_i                     one instruction retired this cycle, capture the record fields
//   pc_i, instr_i                retired PC and instruction word
//   reg_addr_i, reg_data_i       write-back destination (0 = none) and data
//   mem_addr_i, mem_data_i       store address (0 = none) and data
//   trace                        master side of the trace word stream
//   level_o                      records held, including the one being drained
//   retired_count_o              update_i pulses since reset, wraps at 2^32
//   overflow_o                   sticky, a record was dropped because the FIFO was full
module retire_trace_buffer #(
   parameter int XLEN  = 32,
   parameter int DEPTH = 16
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     update_i,
   input  logic [XLEN-1:0]          pc_i,
   input  logic [XLEN-1:0]          instr_i,
   input  logic [4:0]               reg_addr_i,
   input  logic [XLEN-1:0]          reg_data_i,
   input  logic [XLEN-1:0]          mem_addr_i,
   input  logic [XLEN-1:0]          mem_data_i,
   retire_trace_buffer_if.master    trace,
   output logic [$clog2(DEPTH):0]   level_o,
   output logic [31:0]              retired_count_o,
   output logic                     overflow_o
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] SEND = 1'b1;
   logic [XLEN-1:0] pc_m [DEPTH];
   logic [XLEN-1:0] instr_m [DEPTH];
   logic [4:0]      ra_m [DEPTH];
   logic [XLEN-1:0] rd_m [DEPTH];
   logic [XLEN-1:0] ma_m [DEPTH];
   logic [XLEN-1:0] md_m [DEPTH];
   logic [AW-1:0]   wp_q, wp_d, rp_q, rp_d;
   logic [AW:0]     cnt_q, cnt_d;
   logic [2:0]      widx_q, widx_d;
   logic [31:0]     rc_q, rc_d;
   logic            ovf_q, ovf_d;
   logic [0:0]      state;
   logic            push, pop, xfer;
   logic [XLEN-1:0] word;
   // Full is judged on the pre-edge count, so a same-edge pop never makes room.
   always_comb begin
      state  = (cnt_q != '0) ? SEND : IDLE;
      xfer   = (state == SEND) & trace.ready;
      push   = update_i & (cnt_q != FULL);
      pop    = xfer & (widx_q == 3'd5);
      wp_d   = push ? wp_q + 1'b1 : wp_q;
      rp_d   = pop ? rp_q + 1'b1 : rp_q;
      cnt_d  = cnt_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
      widx_d = !xfer ? widx_q : pop ? 3'd0 : widx_q + 3'd1;
      rc_d   = rc_q + {31'b0, update_i};
      ovf_d  = ovf_q | (update_i & ~push);
      word   = (widx_q == 3'd0) ? pc_m[rp_q] :
               (widx_q == 3'd1) ? instr_m[rp_q] :
               (widx_q == 3'd2) ? {{(XLEN-5){1'b0}}, ra_m[rp_q]} :
               (widx_q == 3'd3) ? rd_m[rp_q] :
               (widx_q == 3'd4) ? ma_m[rp_q] : md_m[rp_q];
      trace.valid = (state == SEND);
      trace.last  = (state == SEND) & (widx_q == 3'd5);
      trace.data  = (state == SEND) ? word : '0;
   end
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wp_q   <= '0;
         rp_q   <= '0;
         cnt_q  <= '0;
         widx_q <= '0;
         rc_q   <= '0;
         ovf_q  <= 1'b0;
      end else begin
         wp_q   <= wp_d;
         rp_q   <= rp_d;
         cnt_q  <= cnt_d;
         widx_q <= widx_d;
         rc_q   <= rc_d;
         ovf_q  <= ovf_d;
      end
   end
   // Writes only land on the non-full tail, so the entry being drained is never touched.
   always_ff @(posedge clk_i) begin
      if (push && !rst_i) begin
         pc_m[wp_q]    <= pc_i;
         instr_m[wp_q] <= instr_i;
         ra_m[wp_q]    <= reg_addr_i;
         rd_m[wp_q]    <= reg_data_i;
         ma_m[wp_q]    <= mem_addr_i;
         md_m[wp_q]    <= mem_data_i;
      end
   end
   assign level_o         = cnt_q;
   assign retired_count_o = rc_q;
   assign overflow_o      = ovf_q;
endmodule

// File: tb/tb_retire_trace_buffer.sv
// tb_retire_trace_buffer: directed self-checking bench for retire_trace_buffer
module tb_retire_trace_buffer;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        update = 1'b0;
   logic [31:0] pc = '0, instr = '0, rd = '0, ma = '0, md = '0;
   logic [4:0]  ra = '0;
   logic [4:0]  level;
   logic [31:0] rc;
   logic        ovf;
   int          checks = 0;
   int          failures = 0;
   logic [31:0] exp_w [6] = '{32'h80000000, 32'h00500093, 32'h1, 32'h5, 32'h0, 32'h0};

   retire_trace_buffer_if #(.XLEN(32)) tr ();

   retire_trace_buffer #(.XLEN(32), .DEPTH(16)) dut (
      .clk_i(clk), .rst_i(rst), .update_i(update), .pc_i(pc), .instr_i(instr),
      .reg_addr_i(ra), .reg_data_i(rd), .mem_addr_i(ma), .mem_data_i(md),
      .trace(tr), .level_o(level), .retired_count_o(rc), .overflow_o(ovf)
   );

   always #5 clk = ~clk;

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      rst = 1'b1;
      update = 1'b0;
      tr.ready = 1'b0;
      step;
      rst = 1'b0;
   endtask

   task automatic push_rec(input logic [31:0] p, i, input logic [4:0] a, input logic [31:0] d, m, n);
      pc = p; instr = i; ra = a; rd = d; ma = m; md = n;
      update = 1'b1;
      step;
      update = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      update = 1'b1;
      tr.ready = 1'b1;
      pc = 32'hdeadbeef;
      step;
      step;
      rst = 1'b0;
      update = 1'b0;
      checks++;
      if (tr.valid !== 1'b0 || tr.last !== 1'b0 || tr.data !== 32'h0) begin
         failures++;
         $display("FAIL reset_stream got valid=%b last=%b data=%h exp 0 0 0", tr.valid, tr.last, tr.data);
      end
      checks++;
      if (level !== 5'd0 || rc !== 32'd0 || ovf !== 1'b0) begin
         failures++;
         $display("FAIL reset_regs got level=%0d count=%0d ovf=%b exp 0 0 0", level, rc, ovf);
      end
   endtask

   task automatic test_single;
      do_reset;
      tr.ready = 1'b1;
      push_rec(32'h80000000, 32'h00500093, 5'd1, 32'd5, 32'd0, 32'd0);
      checks++;
      if (level !== 5'd1) begin
         failures++;
         $display("FAIL single_level got=%0d exp=1", level);
      end
      for (int k = 0; k < 6; k++) begin
         checks++;
         if (tr.valid !== 1'b1 || tr.data !== exp_w[k] || tr.last !== (k == 5)) begin
            failures++;
            $display("FAIL single_word%0d got valid=%b data=%h last=%b exp 1 %h %b", k, tr.valid, tr.data, tr.last, exp_w[k], k == 5);
         end
         step;
      end
      checks++;
      if (tr.valid !== 1'b0 || level !== 5'd0 || rc !== 32'd1) begin
         failures++;
         $display("FAIL single_end got valid=%b level=%0d count=%0d exp 0 0 1", tr.valid, level, rc);
      end
   endtask

   task automatic test_backpressure;
      logic pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
      int k = 0;
      int cyc = 0;
      do_reset;
      push_rec(32'h80000000, 32'h00500093, 5'd1, 32'd5, 32'd0, 32'd0);
      while (k < 6 && cyc < 40) begin
         tr.ready = pat[cyc % 4];
         checks++;
         if (tr.valid !== 1'b1 || tr.data !== exp_w[k] || tr.last !== (k == 5)) begin
            failures++;
            $display("FAIL bp_word%0d cyc%0d got valid=%b data=%h last=%b exp 1 %h %b", k, cyc, tr.valid, tr.data, tr.last, exp_w[k], k == 5);
         end
         if (tr.ready) k++;
         cyc++;
         step;
      end
      checks++;
      if (k != 6) begin
         failures++;
         $display("FAIL bp_timeout got transfers=%0d exp 6", k);
      end
      for (int c = 0; c < 4; c++) begin
         tr.ready = pat[c];
         checks++;
         if (tr.valid !== 1'b0 || level !== 5'd0) begin
            failures++;
            $display("FAIL bp_after%0d got valid=%b level=%0d exp 0 0", c, tr.valid, level);
         end
         step;
      end
   endtask

   task automatic test_overflow;
      do_reset;
      for (int k = 0; k < 20; k++) begin
         push_rec(32'(4 * k), 32'(k), 5'(k), ~32'(k), 32'(k + 100), 32'(k * 3));
         checks++;
         if (ovf !== (k >= 16) || level !== 5'((k < 16) ? k + 1 : 16)) begin
            failures++;
            $display("FAIL ovf_pulse%0d got ovf=%b level=%0d exp %b %0d", k + 1, ovf, level, k >= 16, (k < 16) ? k + 1 : 16);
         end
      end
      checks++;
      if (rc !== 32'd20) begin
         failures++;
         $display("FAIL ovf_count got=%0d exp=20", rc);
      end
      tr.ready = 1'b1;
      for (int r = 0; r < 16; r++) begin
         for (int w = 0; w < 6; w++) begin
            if (w == 0) begin
               checks++;
               if (tr.valid !== 1'b1 || tr.data !== 32'(4 * r)) begin
                  failures++;
                  $display("FAIL ovf_drain_rec%0d got valid=%b pc=%h exp 1 %h", r, tr.valid, tr.data, 4 * r);
               end
            end
            if (w == 2) begin
               checks++;
               if (tr.data !== 32'(r)) begin
                  failures++;
                  $display("FAIL ovf_drain_ra%0d got=%h exp=%h", r, tr.data, r);
               end
            end
            step;
         end
      end
      checks++;
      if (tr.valid !== 1'b0 || level !== 5'd0 || ovf !== 1'b1) begin
         failures++;
         $display("FAIL ovf_drained got valid=%b level=%0d ovf=%b exp 0 0 1", tr.valid, level, ovf);
      end
   endtask

   task automatic test_push_pop_full;
      do_reset;
      for (int k = 0; k < 16; k++) push_rec(32'(4 * k), 32'(k), 5'(k), 32'(k), 32'(k), 32'(k + 7));
      tr.ready = 1'b1;
      repeat (5) step;
      checks++;
      if (tr.last !== 1'b1 || tr.data !== 32'd7 || ovf !== 1'b0) begin
         failures++;
         $display("FAIL ppf_word5 got last=%b data=%h ovf=%b exp 1 00000007 0", tr.last, tr.data, ovf);
      end
      push_rec(32'hdead0000, 32'h1, 5'd1, 32'h1, 32'h1, 32'h1);
      checks++;
      if (level !== 5'd15 || ovf !== 1'b1 || rc !== 32'd17) begin
         failures++;
         $display("FAIL ppf_after got level=%0d ovf=%b count=%0d exp 15 1 17", level, ovf, rc);
      end
      for (int r = 0; r < 15; r++) begin
         checks++;
         if (tr.data !== 32'(4 * (r + 1))) begin
            failures++;
            $display("FAIL ppf_drain_rec%0d got pc=%h exp %h", r, tr.data, 4 * (r + 1));
         end
         repeat (6) step;
      end
      checks++;
      if (tr.valid !== 1'b0) begin
         failures++;
         $display("FAIL ppf_drained got valid=%b exp 0", tr.valid);
      end
   endtask

   task automatic test_concurrent;
      logic [31:0] pcs [3] = '{32'h200, 32'h300, 32'h400};
      do_reset;
      push_rec(32'h100, 32'h1, 5'd1, 32'h1, 32'h1, 32'h1);
      push_rec(32'h200, 32'h2, 5'd2, 32'h2, 32'h2, 32'h2);
      push_rec(32'h300, 32'h3, 5'd3, 32'h3, 32'h3, 32'h3);
      tr.ready = 1'b1;
      repeat (5) step;
      push_rec(32'h400, 32'h4, 5'd4, 32'h4, 32'h4, 32'h4);
      checks++;
      if (level !== 5'd3 || ovf !== 1'b0) begin
         failures++;
         $display("FAIL conc_level got level=%0d ovf=%b exp 3 0", level, ovf);
      end
      for (int r = 0; r < 3; r++) begin
         checks++;
         if (tr.valid !== 1'b1 || tr.data !== pcs[r]) begin
            failures++;
            $display("FAIL conc_rec%0d got valid=%b pc=%h exp 1 %h", r, tr.valid, tr.data, pcs[r]);
         end
         step;
         checks++;
         if (tr.data !== pcs[r] >> 8) begin
            failures++;
            $display("FAIL conc_instr%0d got=%h exp=%h", r, tr.data, pcs[r] >> 8);
         end
         repeat (5) step;
      end
      checks++;
      if (tr.valid !== 1'b0 || level !== 5'd0) begin
         failures++;
         $display("FAIL conc_end got valid=%b level=%0d exp 0 0", tr.valid, level);
      end
   endtask

   task automatic test_reset_mid;
      do_reset;
      tr.ready = 1'b1;
      push_rec(32'h80000000, 32'h00500093, 5'd1, 32'd5, 32'd0, 32'd0);
      repeat (3) step;
      checks++;
      if (tr.data !== 32'h5) begin
         failures++;
         $display("FAIL rmid_pre got=%h exp=00000005", tr.data);
      end
      rst = 1'b1;
      step;
      rst = 1'b0;
      checks++;
      if (tr.valid !== 1'b0 || tr.data !== 32'h0 || tr.last !== 1'b0 || level !== 5'd0 || rc !== 32'd0 || ovf !== 1'b0) begin
         failures++;
         $display("FAIL rmid_clear got valid=%b data=%h last=%b level=%0d count=%0d ovf=%b exp all 0", tr.valid, tr.data, tr.last, level, rc, ovf);
      end
      push_rec(32'h12340000, 32'h2, 5'd2, 32'h2, 32'h2, 32'h2);
      checks++;
      if (tr.valid !== 1'b1 || tr.data !== 32'h12340000 || tr.last !== 1'b0) begin
         failures++;
         $display("FAIL rmid_first got valid=%b data=%h last=%b exp 1 12340000 0", tr.valid, tr.data, tr.last);
      end
   endtask

   initial begin
      tr.ready = 1'b0;
      test_reset;
      test_single;
      test_backpressure;
      test_overflow;
      test_push_pop_full;
      test_concurrent;
      test_reset_mid;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1, "watchdog");
   end
endmodule
